// File: rtl/universal_shift_pkg.sv
// universal_shift_pkg: shared mode codes, FSM state encoding and direction constants
//   MODE_*    3-bit command codes
//   state_t   IDLE/SHIFT/DONE encoding
//   DIR_*     serial-out direction flag values
package universal_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_CLR  = 3'd2;
    localparam logic [2:0] MODE_SHL  = 3'd3;
    localparam logic [2:0] MODE_SHR  = 3'd4;
    localparam logic [2:0] MODE_ROTL = 3'd5;
    localparam logic [2:0] MODE_ROTR = 3'd6;
    localparam logic [2:0] MODE_ASR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic is_shift(input logic [2:0] m);
        return m >= MODE_SHL;
    endfunction

    function automatic logic is_left(input logic [2:0] m);
        return m == MODE_SHL || m == MODE_ROTL;
    endfunction

endpackage

// File: rtl/universal_shift_step.sv
// universal_shift_step: one-step combinational next value for the shift/rotate modes
//   q     current register value
//   mode  command code; non-shift modes pass q through
//   sin   serial fill bit for SHL/SHR
//   next  value after one step
module universal_shift_step
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = q;
        case (mode)
            MODE_SHL:  next = {q[WIDTH-2:0], sin};
            MODE_SHR:  next = {sin, q[WIDTH-1:1]};
            MODE_ROTL: next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR: next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   next = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit load/clear/shift/rotate register with start/busy/done handshake
//   clk, rst     clock, asynchronous active-low reset
//   start        command request, sampled while idle
//   mode, amt    command code and shift count, captured on accept
//   D            parallel load data
//   sin          serial fill bit, sampled on every shift edge
//   Q            register contents
//   busy, done   command in progress / final cycle of command
//   sout         Q msb after left-type commands, Q lsb after right-type
module universal_shift_register
    import universal_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             sout
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   remaining;
    logic [2:0]         mode_r;
    logic               dir;
    logic [WIDTH-1:0]   step_q;
    logic               accept;

    assign accept = state == IDLE && start;

    // The first shift happens on the accept edge, before mode_r is valid
    universal_shift_step #(.WIDTH(WIDTH)) u_step (
        .q    (Q),
        .mode (state == IDLE ? mode : mode_r),
        .sin  (sin),
        .next (step_q)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (is_shift(mode) && amt > CNT_W'(1)) ? SHIFT : DONE;
            SHIFT:   if (remaining == CNT_W'(1)) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            Q         <= '0;
            remaining <= '0;
            mode_r    <= MODE_HOLD;
            dir       <= DIR_LEFT;
        end else begin
            state <= state_n;
            if (accept) begin
                mode_r    <= mode;
                remaining <= (amt == '0) ? '0 : amt - 1'b1;
                if (is_shift(mode)) dir <= is_left(mode) ? DIR_LEFT : DIR_RIGHT;
                Q <= (mode == MODE_LOAD) ? D :
                     (mode == MODE_CLR) ? '0 :
                     (is_shift(mode) && amt != '0) ? step_q : Q;
            end else if (state == SHIFT) begin
                remaining <= remaining - 1'b1;
                Q         <= step_q;
            end
        end
    end

    assign busy = state != IDLE;
    assign done = state == DONE;
    assign sout = (dir == DIR_LEFT) ? Q[WIDTH-1] : Q[0];

endmodule
